// File: rtl/vga_pkg.sv
// Shared timing constants, RGB332 field positions and write-side state encoding
// for the VGA line buffer.
package vga_pkg;

    localparam logic [9:0] HPIXELS = 10'd800;
    localparam logic [9:0] VLINES  = 10'd521;
    localparam logic [9:0] HBP     = 10'd144;
    localparam logic [9:0] HFP     = 10'd784;
    localparam logic [9:0] VBP     = 10'd31;
    localparam logic [9:0] VFP     = 10'd511;
    localparam logic [9:0] HACTIVE = HFP - HBP;

    localparam int R_HI = 7;
    localparam int R_LO = 5;
    localparam int G_HI = 4;
    localparam int G_LO = 2;
    localparam int B_HI = 1;
    localparam int B_LO = 0;

    typedef enum logic {
        WS_FILL = 1'b0,
        WS_FULL = 1'b1
    } wstate_e;

    // True when the line after v (wrapping at the frame end) is an active video line.
    function automatic logic next_line_active(input logic [9:0] v);
        logic [9:0] nv;
        nv = (v == VLINES - 10'd1) ? 10'd0 : v + 10'd1;
        return (nv >= VBP) && (nv < VFP);
    endfunction

endpackage

// File: rtl/vga_line_ram.sv
// Two 640x8 line banks with one write port and one registered read port;
// the bank select acts as the address MSB.
module vga_line_ram
    import vga_pkg::*;
(
    input  logic       clk_i,
    input  logic       we_i,
    input  logic       wbank_i,
    input  logic [9:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic       rbank_i,
    input  logic [9:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem [2][HACTIVE];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[wbank_i][waddr_i] <= wdata_i;
        end
        rdata_q <= mem[rbank_i][raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_line_buffer.sv
// Ping-pong line buffer: fills one bank from a pixel stream while replaying the
// other in step with hc/vc, with syncs delayed to match the 2-cycle read path.
module vga_line_buffer
    import vga_pkg::*;
(
    input  logic       dclk,
    input  logic       clr_n,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_sof,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       underrun,
    output logic       resync,
    output logic       dbg_state_o,
    output logic [9:0] dbg_wcount_o
);

    // Stream handshake: a pixel transfers on every rising dclk where s_valid and
    // s_ready are both 1; s_ready is registered and never depends on s_valid.

    wstate_e    state_q;
    logic [9:0] wcount_q;
    logic       wbank_q;
    logic       rd_valid_q;
    logic       s_ready_q;
    logic       underrun_q;
    logic       resync_q;

    logic       hs;
    logic       sof_restart;
    logic [9:0] waddr;
    logic [9:0] wcount_d;
    logic       last_px;
    logic       swap_pt;
    logic       bank_full;

    assign hs          = s_valid & s_ready_q;
    assign sof_restart = hs & s_sof & (wcount_q != 10'd0);
    assign waddr       = sof_restart ? 10'd0 : wcount_q;
    assign wcount_d    = waddr + 10'd1;
    assign last_px     = hs & (wcount_d == HACTIVE);
    assign swap_pt     = (hc == HPIXELS - 10'd1) & next_line_active(vc);
    assign bank_full   = (state_q == WS_FULL) | last_px;

    always_ff @(posedge dclk) begin
        if (!clr_n) begin
            state_q    <= WS_FILL;
            wcount_q   <= 10'd0;
            wbank_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            s_ready_q  <= 1'b0;
            underrun_q <= 1'b0;
            resync_q   <= 1'b0;
        end else begin
            resync_q   <= sof_restart;
            underrun_q <= swap_pt & ~bank_full;
            if (swap_pt && bank_full) begin
                wbank_q    <= ~wbank_q;
                rd_valid_q <= 1'b1;
                wcount_q   <= 10'd0;
                state_q    <= WS_FILL;
                s_ready_q  <= 1'b1;
            end else begin
                // A partial bank keeps filling across the missed swap; only the display blanks.
                if (swap_pt) begin
                    rd_valid_q <= 1'b0;
                end
                if (hs) begin
                    wcount_q <= wcount_d;
                end
                if (last_px) begin
                    state_q   <= WS_FULL;
                    s_ready_q <= 1'b0;
                end else begin
                    s_ready_q <= (state_q == WS_FILL);
                end
            end
        end
    end

    logic       h_act;
    logic       v_act;
    logic       de_now;
    logic [9:0] raddr;
    logic       rbank;
    logic [7:0] ram_rdata;
    logic       de1_q;
    logic       hs1_q;
    logic       vs1_q;
    logic       hsync_q;
    logic       vsync_q;
    logic [7:0] rgb_q;

    assign h_act  = (hc >= HBP) & (hc < HFP);
    assign v_act  = (vc >= VBP) & (vc < VFP);
    assign de_now = h_act & v_act & rd_valid_q;
    assign raddr  = de_now ? (hc - HBP) : 10'd0;
    assign rbank  = ~wbank_q;

    vga_line_ram u_ram (
        .clk_i   (dclk),
        .we_i    (hs),
        .wbank_i (wbank_q),
        .waddr_i (waddr),
        .wdata_i (s_data),
        .rbank_i (rbank),
        .raddr_i (raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge dclk) begin
        if (!clr_n) begin
            de1_q   <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 8'd0;
        end else begin
            de1_q   <= de_now;
            hs1_q   <= hsync_i;
            vs1_q   <= vsync_i;
            hsync_q <= hs1_q;
            vsync_q <= vs1_q;
            rgb_q   <= de1_q ? ram_rdata : 8'd0;
        end
    end

    assign s_ready      = s_ready_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign red          = rgb_q[R_HI:R_LO];
    assign green        = rgb_q[G_HI:G_LO];
    assign blue         = rgb_q[B_HI:B_LO];
    assign underrun     = underrun_q;
    assign resync       = resync_q;
    assign dbg_state_o  = state_q;
    assign dbg_wcount_o = wcount_q;

endmodule

// File: tb/tb_vga_line_buffer.sv
// Directed bench for vga_line_buffer: a table of whole-line scenarios plus
// hand-written reset and sync-wrap sequences, checked against a line model.
module tb_vga_line_buffer;

    logic       dclk;
    logic       clr_n;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       hsync_i;
    logic       vsync_i;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_sof;
    logic       hsync;
    logic       vsync;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
    logic       underrun;
    logic       resync;
    logic       dbg_state_o;
    logic [9:0] dbg_wcount_o;

    vga_line_buffer dut (
        .dclk         (dclk),
        .clr_n        (clr_n),
        .hc           (hc),
        .vc           (vc),
        .hsync_i      (hsync_i),
        .vsync_i      (vsync_i),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_sof        (s_sof),
        .hsync        (hsync),
        .vsync        (vsync),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .underrun     (underrun),
        .resync       (resync),
        .dbg_state_o  (dbg_state_o),
        .dbg_wcount_o (dbg_wcount_o)
    );

    // Clock / reset
    initial begin
        dclk = 1'b0;
        forever #20 dclk = ~dclk;
    end

    typedef struct {
        int vline;
        int n_feed;
        int sof_idx;
        int base;
        int exp_acc;
        int exp_under;
        int exp_resync;
        int exp_wcount;
        int exp_rdy0;
        int exp_rdy799;
    } vec_t;

    vec_t       tbl [12];
    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q [$];
    logic [7:0] fill_buf [640];
    logic [7:0] show_buf [640];
    bit         show_valid;
    int         mwcount;
    int         acc_cnt;
    int         under_cnt;
    int         resync_cnt;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one dclk cycle, updates the line model, then compares outputs.
    task automatic cyc(input int h, input int v, input bit valid, input logic [7:0] data,
                       input bit sof, output bit acc);
        logic [7:0] e_rgb;
        logic [9:0] e;
        int         nv;
        hc      = 10'(h);
        vc      = 10'(v);
        hsync_i = (h >= 96);
        vsync_i = (v >= 2);
        s_valid = valid;
        s_data  = data;
        s_sof   = sof;
        if (h >= 144 && h < 784 && v >= 31 && v < 511 && show_valid) e_rgb = show_buf[h - 144];
        else e_rgb = 8'd0;
        exp_q.push_back({hsync_i, vsync_i, e_rgb});
        acc = valid && s_ready;
        if (acc) begin
            acc_cnt++;
            if (sof && mwcount != 0) begin
                fill_buf[0] = data;
                mwcount = 1;
            end else if (mwcount < 640) begin
                fill_buf[mwcount] = data;
                mwcount++;
            end
        end
        if (h == 799) begin
            nv = (v == 520) ? 0 : v + 1;
            if (nv >= 31 && nv < 511) begin
                if (mwcount == 640) begin
                    show_buf   = fill_buf;
                    show_valid = 1'b1;
                    mwcount    = 0;
                end else begin
                    show_valid = 1'b0;
                end
            end
        end
        @(posedge dclk);
        #1;
        if (underrun) under_cnt++;
        if (resync) resync_cnt++;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            check("pix_sync", {hsync, vsync, red, green, blue}, e);
        end
    endtask

    task automatic run_line(input int row);
        int fed;
        bit acc;
        bit valid;
        bit rdy0;
        bit rdy799;
        fed        = 0;
        acc_cnt    = 0;
        under_cnt  = 0;
        resync_cnt = 0;
        rdy0       = 1'b0;
        rdy799     = 1'b0;
        for (int h = 0; h < 800; h++) begin
            valid = (fed < tbl[row].n_feed);
            if (h == 0) rdy0 = s_ready;
            if (h == 799) rdy799 = s_ready;
            cyc(h, tbl[row].vline, valid, 8'(tbl[row].base + fed),
                valid && (fed == tbl[row].sof_idx), acc);
            if (acc) fed++;
        end
        check($sformatf("row%0d_accepted", row), acc_cnt, tbl[row].exp_acc);
        check($sformatf("row%0d_underrun", row), under_cnt, tbl[row].exp_under);
        check($sformatf("row%0d_resync", row), resync_cnt, tbl[row].exp_resync);
        check($sformatf("row%0d_wcount", row), int'(dbg_wcount_o), tbl[row].exp_wcount);
        check($sformatf("row%0d_ready_hc0", row), int'(rdy0), tbl[row].exp_rdy0);
        check($sformatf("row%0d_ready_hc799", row), int'(rdy799), tbl[row].exp_rdy799);
    endtask

    initial begin
        bit dummy;
        //           vline feed  sof  base acc  und rsy wcnt rdy0 rdy799
        tbl[0]  = '{40,   640,  -1,  0,   640, 0,  0,  0,   1,   0};  // fill; first line black
        tbl[1]  = '{41,   700,  -1,  100, 640, 0,  0,  0,   1,   0};  // ramp shown; backpressure
        tbl[2]  = '{42,   300,  -1,  50,  300, 1,  0,  300, 1,   1};  // underrun
        tbl[3]  = '{43,   340,  -1,  60,  340, 0,  0,  0,   1,   0};  // black line, fill resumes
        tbl[4]  = '{44,   200,  100, 7,   200, 1,  1,  100, 1,   1};  // resync at pixel 100
        tbl[5]  = '{45,   540,  -1,  200, 540, 0,  0,  0,   1,   0};  // complete resynced bank
        tbl[6]  = '{46,   0,    -1,  0,   0,   1,  0,  0,   1,   1};  // resynced bank shown
        tbl[7]  = '{520,  0,    -1,  0,   0,   0,  0,  0,   1,   1};  // frame end, no swap point
        tbl[8]  = '{0,    0,    -1,  0,   0,   0,  0,  0,   1,   1};  // vsync region
        tbl[9]  = '{30,   640,  0,   3,   640, 0,  0,  0,   1,   0};  // sof at wcount 0 is a marker
        tbl[10] = '{31,   0,    -1,  0,   0,   1,  0,  0,   1,   1};  // first active line
        tbl[11] = '{510,  0,    -1,  0,   0,   0,  0,  0,   1,   1};  // last active line, no swap

        clr_n   = 1'b0;
        hc      = 10'd0;
        vc      = 10'd20;
        hsync_i = 1'b1;
        vsync_i = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'd0;
        s_sof   = 1'b0;
        repeat (2) @(posedge dclk);
        #1;
        clr_n = 1'b1;

        // Some mid-line traffic before the checked reset
        for (int h = 200; h < 260; h++) begin
            hc      = 10'(h);
            vc      = 10'd40;
            s_valid = 1'b1;
            s_data  = 8'(h);
            @(posedge dclk);
            #1;
        end

        clr_n   = 1'b0;
        hsync_i = 1'b0;
        vsync_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hc = 10'(260 + i);
            @(posedge dclk);
            #1;
            check("reset_outputs", {s_ready, red, green, blue, hsync, vsync, underrun, resync},
                  13'h000C);
        end
        check("reset_wcount", int'(dbg_wcount_o), 0);
        check("reset_state", int'(dbg_state_o), 0);

        clr_n = 1'b1;
        exp_q.delete();
        mwcount    = 0;
        show_valid = 1'b0;
        cyc(798, 20, 1'b0, 8'd0, 1'b0, dummy);
        check("ready_after_reset", int'(s_ready), 1);
        cyc(799, 20, 1'b0, 8'd0, 1'b0, dummy);

        for (int r = 0; r < 12; r++) begin
            run_line(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
